// File: rtl/bisonn_mac_requester.sv
// Dot-product initiator for the multiplier side port: issues operand pairs while
// the scalar MUL is idle, accumulates fixed-latency results and hands back the sum.
module bisonn_mac_requester #(
  parameter int LEN_W   = 16,
  parameter int MUL_LAT = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  input  logic             flush_i,
  input  logic             op_valid_i,
  input  logic [63:0]      op_a_i,
  input  logic [63:0]      op_b_i,
  output logic             op_ready_o,
  input  logic             mul_free_i,
  output logic             bisonn_valid_o,
  output logic [63:0]      bisonn_rs1_o,
  output logic [63:0]      bisonn_rs2_o,
  input  logic             bisonn_valid_i,
  input  logic [63:0]      bisonn_rd_i,
  output logic             acc_valid_o,
  output logic [63:0]      acc_o,
  input  logic             acc_ready_i
);

  if (MUL_LAT < 1) begin : g_bad_lat
    $error("MUL_LAT must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, FLUSH} state_t;

  localparam logic [LEN_W:0] ONE = {{LEN_W{1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W:0]   issued_q, issued_d, returned_q, returned_d, len_ext;
  logic [63:0]      acc_q, acc_d;
  logic             fire;

  assign len_ext = {1'b0, len_q};
  assign fire    = (state_q == RUN) & op_valid_i & mul_free_i & (issued_q < len_ext) & ~flush_i;

  assign op_ready_o     = fire;
  assign bisonn_valid_o = fire;
  assign bisonn_rs1_o   = fire ? op_a_i : '0;
  assign bisonn_rs2_o   = fire ? op_b_i : '0;

  assign busy_o      = (state_q != IDLE);
  assign acc_valid_o = (state_q == DONE);
  assign acc_o       = acc_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    acc_d      = acc_q;
    unique case (state_q)
      IDLE: begin
        if (!flush_i && start_i) begin
          len_d      = len_i;
          acc_d      = '0;
          issued_d   = '0;
          returned_d = '0;
          state_d    = (len_i == '0) ? DONE : RUN;
        end
      end
      RUN, DRAIN: begin
        if (bisonn_valid_i) returned_d = returned_q + ONE;
        if (flush_i) begin
          // A result landing in the flush cycle is retired but never summed.
          state_d = (issued_q == returned_d) ? IDLE : FLUSH;
        end else begin
          if (fire) issued_d = issued_q + ONE;
          if (bisonn_valid_i) acc_d = acc_q + bisonn_rd_i;
          if (returned_d == len_ext)    state_d = DONE;
          else if (issued_d == len_ext) state_d = DRAIN;
        end
      end
      DONE: begin
        if (acc_ready_i || flush_i) state_d = IDLE;
      end
      FLUSH: begin
        // Side-port pipe cannot be cancelled; swallow what is still in flight.
        if (bisonn_valid_i) returned_d = returned_q + ONE;
        if (returned_d == issued_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      acc_q      <= acc_d;
    end
  end

endmodule

// File: tb/tb_bisonn_mac_requester.sv
// Bench for bisonn_mac_requester: directed jobs plus random jobs against a
// sum-of-products reference, with a fixed-latency multiplier stand-in.
module tb_bisonn_mac_requester;
  localparam int LEN_W   = 16;
  localparam int MUL_LAT = 2;

  logic             clk_i = 1'b0;
  logic             rstn_i;
  logic             start_i, flush_i, op_valid_i, mul_free_i, acc_ready_i;
  logic [LEN_W-1:0] len_i;
  logic [63:0]      op_a_i, op_b_i;
  logic             busy_o, op_ready_o, bisonn_valid_o, acc_valid_o;
  logic [63:0]      bisonn_rs1_o, bisonn_rs2_o, acc_o;
  logic             bisonn_valid_i;
  logic [63:0]      bisonn_rd_i;

  logic             stray_v;
  logic [63:0]      stray_d;
  logic [MUL_LAT-1:0] vld_pipe;
  logic [63:0]      dat_pipe [MUL_LAT];

  int checks = 0, failures = 0;
  logic [63:0] qa [$], qb [$];
  logic [63:0] last_sum;

  always #5 clk_i = ~clk_i;

  bisonn_mac_requester #(.LEN_W(LEN_W), .MUL_LAT(MUL_LAT)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .len_i(len_i), .busy_o(busy_o),
    .flush_i(flush_i), .op_valid_i(op_valid_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
    .op_ready_o(op_ready_o), .mul_free_i(mul_free_i), .bisonn_valid_o(bisonn_valid_o),
    .bisonn_rs1_o(bisonn_rs1_o), .bisonn_rs2_o(bisonn_rs2_o), .bisonn_valid_i(bisonn_valid_i),
    .bisonn_rd_i(bisonn_rd_i), .acc_valid_o(acc_valid_o), .acc_o(acc_o), .acc_ready_i(acc_ready_i)
  );

  // Multiplier side port: result MUL_LAT cycles after the issue cycle.
  always @(posedge clk_i) begin
    vld_pipe[0] <= bisonn_valid_o;
    dat_pipe[0] <= bisonn_rs1_o * bisonn_rs2_o;
    for (int i = 1; i < MUL_LAT; i++) begin
      vld_pipe[i] <= vld_pipe[i-1];
      dat_pipe[i] <= dat_pipe[i-1];
    end
  end
  assign bisonn_valid_i = vld_pipe[MUL_LAT-1] | stray_v;
  assign bisonn_rd_i    = stray_v ? stray_d : dat_pipe[MUL_LAT-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // mode 0: always free/valid, 1: mul_free alternates 1,0,..., 2: random
  task automatic run_job(input int mode, input int hold);
    int n, idx, k, t;
    bit v, f;
    logic [63:0] exp_sum;
    n = qa.size(); idx = 0; t = 0; exp_sum = '0;
    chk("idle_busy", busy_o, 0);
    start_i = 1'b1; len_i = n[LEN_W-1:0];
    cyc();
    start_i = 1'b0;
    chk("job_busy", busy_o, 1);
    if (n == 0) begin
      op_valid_i = 1'b1; mul_free_i = 1'b1;
      #1;
      chk("len0_valid", acc_valid_o, 1);
      chk("len0_no_issue", bisonn_valid_o, 0);
      op_valid_i = 1'b0;
    end else begin
      while (idx < n && t < 400) begin
        case (mode)
          0:       begin v = 1'b1; f = 1'b1; end
          1:       begin v = 1'b1; f = (t % 2 == 0); end
          default: begin v = ($urandom % 4 != 0); f = ($urandom % 3 != 0); end
        endcase
        op_valid_i = v; mul_free_i = f; op_a_i = qa[idx]; op_b_i = qb[idx];
        #1;
        chk("op_ready", op_ready_o, v & f);
        chk("issue_valid", bisonn_valid_o, v & f);
        if (v & f) begin
          chk("rs1", bisonn_rs1_o, qa[idx]);
          chk("rs2", bisonn_rs2_o, qb[idx]);
          exp_sum += qa[idx] * qb[idx];
          idx++;
        end
        cyc();
        t++;
      end
      chk("issue_count", idx, n);
      op_valid_i = 1'b0; op_a_i = '0; op_b_i = '0; mul_free_i = 1'b1;
      k = 1;
      while (!acc_valid_o && k < 20) begin
        cyc();
        k++;
      end
      chk("done_latency", k, MUL_LAT + 1);
    end
    chk("acc", acc_o, exp_sum);
    for (int i = 0; i < hold; i++) begin
      start_i = (i == hold / 2);
      stray_v = (i == 1);
      stray_d = {$urandom, $urandom};
      cyc();
      start_i = 1'b0; stray_v = 1'b0;
      chk("bp_valid", acc_valid_o, 1);
      chk("bp_acc", acc_o, exp_sum);
    end
    acc_ready_i = 1'b1;
    cyc();
    acc_ready_i = 1'b0;
    chk("release_valid", acc_valid_o, 0);
    chk("release_busy", busy_o, 0);
    last_sum = exp_sum;
    qa.delete(); qb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rstn_i = 1'b0; start_i = 1'b0; flush_i = 1'b0; acc_ready_i = 1'b0;
    op_valid_i = 1'b1; mul_free_i = 1'b1; len_i = '0; op_a_i = '1; op_b_i = '1;
    stray_v = 1'b0; stray_d = '0; last_sum = '0;
    repeat (4) cyc();
    chk("rst_busy", busy_o, 0);
    chk("rst_acc_valid", acc_valid_o, 0);
    chk("rst_acc", acc_o, 0);
    chk("rst_op_ready", op_ready_o, 0);
    chk("rst_issue", bisonn_valid_o, 0);
    rstn_i = 1'b1;
    op_valid_i = 1'b0; op_a_i = '0; op_b_i = '0;
    cyc();

    qa = '{64'd2, 64'd3, 64'd4}; qb = '{64'd5, 64'd6, 64'd7};
    run_job(0, 0);
    chk("basic_sum", last_sum, 64'd56);

    qa = '{64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
    qb = '{64'h1_0000_0000, 64'd2, 64'd3};
    run_job(0, 0);
    chk("wrap_sum", last_sum, 64'd1);

    qa = '{64'd11, 64'd12, 64'd13, 64'd14}; qb = '{64'd2, 64'd3, 64'd4, 64'd5};
    run_job(1, 0);

    run_job(0, 0);

    // stray result while idle must not touch the accumulator
    stray_v = 1'b1; stray_d = 64'h1234;
    cyc();
    stray_v = 1'b0;
    cyc();
    chk("stray_idle", acc_o, 64'd0);

    // flush after 5 back-to-back issues of an 8-pair job
    start_i = 1'b1; len_i = 16'd8;
    cyc();
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      op_valid_i = 1'b1; mul_free_i = 1'b1; op_a_i = 64'(i + 1); op_b_i = 64'd3;
      cyc();
    end
    flush_i = 1'b1;
    #1;
    chk("flush_no_issue", op_ready_o, 0);
    cyc();
    flush_i = 1'b0; op_valid_i = 1'b0;
    k = 0;
    while (busy_o && k < 10) begin
      chk("flush_no_acc_valid", acc_valid_o, 0);
      cyc();
      k++;
    end
    chk("flush_busy_fall", busy_o, 0);
    chk("flush_cycles", k, 1);
    chk("flush_drained", vld_pipe, 0);
    chk("flush_acc_valid", acc_valid_o, 0);
    qa = '{64'd7}; qb = '{64'd9};
    run_job(0, 0);
    chk("after_flush_sum", last_sum, 64'd63);

    qa = '{64'd100, 64'd200}; qb = '{64'd3, 64'd4};
    run_job(0, 10);

    for (int j = 0; j < 25; j++) begin
      int n;
      n = $urandom_range(0, 8);
      for (int i = 0; i < n; i++) begin
        qa.push_back({$urandom, $urandom});
        qb.push_back((j % 2) ? 64'($urandom_range(0, 1000)) : {$urandom, $urandom});
      end
      run_job(2, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
